// File: rtl/lif_pkg.sv
// Shared definitions for the lif lattice cells and their readers.
// Direction bit positions are common to the cell update and the population counters.
package lif_pkg;

  localparam int unsigned DIR_W = 4;

  localparam int unsigned DIR_EAST  = 0;
  localparam int unsigned DIR_NORTH = 1;
  localparam int unsigned DIR_WEST  = 2;
  localparam int unsigned DIR_SOUTH = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/lif_dir_counter.sv
// Per-direction particle population accumulators, one per bit of a lif nibble.
module lif_dir_counter
  import lif_pkg::*;
#(
  parameter int unsigned CW = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc_en,
  input  logic [DIR_W-1:0] nibble,
  output logic [CW-1:0]    cnt_east,
  output logic [CW-1:0]    cnt_north,
  output logic [CW-1:0]    cnt_west,
  output logic [CW-1:0]    cnt_south
);

  logic [CW-1:0] cnt_q [DIR_W];
  logic [CW-1:0] cnt_d [DIR_W];

  // Clear wins; capture and transfer are mutually exclusive in the reader anyway.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '{default: '0};
    end else if (inc_en) begin
      cnt_d[DIR_EAST]  = cnt_q[DIR_EAST]  + CW'(nibble[DIR_EAST]);
      cnt_d[DIR_NORTH] = cnt_q[DIR_NORTH] + CW'(nibble[DIR_NORTH]);
      cnt_d[DIR_WEST]  = cnt_q[DIR_WEST]  + CW'(nibble[DIR_WEST]);
      cnt_d[DIR_SOUTH] = cnt_q[DIR_SOUTH] + CW'(nibble[DIR_SOUTH]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_east  = cnt_q[DIR_EAST];
  assign cnt_north = cnt_q[DIR_NORTH];
  assign cnt_west  = cnt_q[DIR_WEST];
  assign cnt_south = cnt_q[DIR_SOUTH];

endmodule

// File: rtl/lif_grid_reader.sv
// Snapshots a row of lif cell states and streams them out one nibble per valid/ready
// handshake, cell 0 first, while accumulating per-direction populations.
module lif_grid_reader
  import lif_pkg::*;
#(
  parameter int unsigned NCELLS = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DIR_W*NCELLS-1:0]         cells_in,
  input  logic                            snap,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DIR_W-1:0]                out_data,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done,
  output logic                            overrun,
  output logic [$clog2(NCELLS+1)-1:0]     cnt_d0,
  output logic [$clog2(NCELLS+1)-1:0]     cnt_d1,
  output logic [$clog2(NCELLS+1)-1:0]     cnt_d2,
  output logic [$clog2(NCELLS+1)-1:0]     cnt_d3
);

  localparam int unsigned CW = $clog2(NCELLS + 1);
  localparam int unsigned IW = $clog2(NCELLS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCELLS - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d, idx_inc;
  logic [DIR_W-1:0] shadow_q [NCELLS];
  logic [DIR_W-1:0] shadow_d [NCELLS];
  logic [DIR_W-1:0] cap_c    [NCELLS];
  logic             out_valid_q, out_valid_d;
  logic [DIR_W-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;
  logic             cnt_clear_c, xfer_c;

  for (genvar g = 0; g < NCELLS; g++) begin : g_cap
    assign cap_c[g] = cells_in[DIR_W*g +: DIR_W];
  end

  assign idx_inc = idx_q + IW'(1);

  // Next-nibble is preloaded from the shadow so out_data stays a flop output.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    overrun_d   = overrun_q;
    cnt_clear_c = 1'b0;
    xfer_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (snap) begin
          shadow_d    = cap_c;
          idx_d       = '0;
          out_valid_d = 1'b1;
          out_data_d  = cap_c[0];
          out_last_d  = 1'b0;
          busy_d      = 1'b1;
          cnt_clear_c = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (snap) overrun_d = 1'b1;
        xfer_c = out_valid_q && out_ready;
        if (xfer_c) begin
          if (idx_q == LAST_IDX) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end else begin
            idx_d      = idx_inc;
            out_data_d = shadow_q[idx_inc];
            out_last_d = (idx_inc == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      shadow_q    <= '{default: '0};
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  lif_dir_counter #(
    .CW(CW)
  ) u_dir_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear_c),
    .inc_en   (xfer_c),
    .nibble   (out_data_q),
    .cnt_east (cnt_d0),
    .cnt_north(cnt_d1),
    .cnt_west (cnt_d2),
    .cnt_south(cnt_d3)
  );

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule
